// File: rtl/aes_result_buffer.sv
// ----------------------------------------------------------------------------
// AesResultBuffer (module aes_result_buffer)
//
// In-order result buffer between the AES32 execution datapath and the CV-X-IF
// result interface. Completed results (id, rd, data) are queued in a circular
// FIFO. A per-ID commit table records commit/kill notifications from the core.
// Results leave strictly in issue order, killed results are dropped silently,
// and nothing is presented before its instruction has been committed.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  datapath result handshake
//   in_id_i, in_rd_i,
//   in_data_i              result payload from the datapath
//   commit_valid_i,
//   commit_id_i,
//   commit_kill_i          commit interface (kill=1 discards the instruction)
//   result_valid_o/
//   result_ready_i         XIF result handshake
//   result_id_o, result_rd_o,
//   result_data_o          head payload, held stable while valid and not ready
//   result_we_o            always 1 (every AES32 instruction writes rd)
//   count_o                current FIFO occupancy
//
// Optional feature macro: AES_RESULT_BYPASS_EN
//   When defined, an already-committed result arriving at an empty buffer is
//   presented combinationally in the same cycle and skips the FIFO if accepted.
// ----------------------------------------------------------------------------
module aes_result_buffer #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [X_ID_WIDTH-1:0]        in_id_i,
    input  logic [4:0]                   in_rd_i,
    input  logic [X_RFW_WIDTH-1:0]       in_data_i,
    input  logic                         commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]        commit_id_i,
    input  logic                         commit_kill_i,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic [X_ID_WIDTH-1:0]        result_id_o,
    output logic [4:0]                   result_rd_o,
    output logic [X_RFW_WIDTH-1:0]       result_data_o,
    output logic                         result_we_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int NUM_IDS = 2 ** X_ID_WIDTH;

    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_WAIT,
        HEAD_DROP,
        HEAD_PRESENT
    } headState_e;

    logic [X_ID_WIDTH-1:0]  idMem_q   [DEPTH];
    logic [4:0]             rdMem_q   [DEPTH];
    logic [X_RFW_WIDTH-1:0] dataMem_q [DEPTH];

    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_IDS-1:0] cmt_q, cmt_d;
    logic [NUM_IDS-1:0] kil_q, kil_d;

    headState_e            headState;
    logic [X_ID_WIDTH-1:0] headId;
    logic                  bypassValid;
    logic                  bypassTake;
    logic                  push;
    logic                  pop;
    logic                  clearEn;
    logic [X_ID_WIDTH-1:0] clearId;

    assign headId = idMem_q[rdPtr_q];

    // Classify the head entry from the registered commit table; this decides
    // whether the head waits, is dropped, or is offered to the core.
    always_comb begin
        headState = HEAD_EMPTY;
        if (count_q != '0) begin
            if (!cmt_q[headId]) begin
                headState = HEAD_WAIT;
            end else if (kil_q[headId]) begin
                headState = HEAD_DROP;
            end else begin
                headState = HEAD_PRESENT;
            end
        end
    end

`ifdef AES_RESULT_BYPASS_EN
    // Same-cycle forwarding: only legal when the buffer is empty, otherwise
    // ordering against older queued results would break.
    assign bypassValid = (count_q == '0) && in_valid_i &&
                         cmt_q[in_id_i] && !kil_q[in_id_i];
`else
    assign bypassValid = 1'b0;
`endif
    assign bypassTake = bypassValid && result_ready_i;

    assign in_ready_o  = (count_q != CNT_W'(DEPTH));
    assign push        = in_valid_i && in_ready_o && !bypassTake;
    assign pop         = (headState == HEAD_DROP) ||
                         ((headState == HEAD_PRESENT) && result_ready_i);
    assign clearEn     = pop || bypassTake;
    assign clearId     = bypassTake ? in_id_i : headId;

    assign result_valid_o = (headState == HEAD_PRESENT) || bypassValid;
    assign result_id_o    = bypassValid ? in_id_i   : headId;
    assign result_rd_o    = bypassValid ? in_rd_i   : rdMem_q[rdPtr_q];
    assign result_data_o  = bypassValid ? in_data_i : dataMem_q[rdPtr_q];
    assign result_we_o    = 1'b1;
    assign count_o        = count_q;

    // Pointer, occupancy and commit-table next state. The commit write is
    // applied after the consume-clear so a commit to the same ID wins.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        cmt_d   = cmt_q;
        kil_d   = kil_q;

        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (clearEn) begin
            cmt_d[clearId] = 1'b0;
            kil_d[clearId] = 1'b0;
        end
        if (commit_valid_i) begin
            cmt_d[commit_id_i] = 1'b1;
            kil_d[commit_id_i] = commit_kill_i;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            cmt_q   <= '0;
            kil_q   <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            cmt_q   <= cmt_d;
            kil_q   <= kil_d;
        end
    end

    // Payload storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                idMem_q[i]   <= '0;
                rdMem_q[i]   <= '0;
                dataMem_q[i] <= '0;
            end
        end else if (push) begin
            idMem_q[wrPtr_q]   <= in_id_i;
            rdMem_q[wrPtr_q]   <= in_rd_i;
            dataMem_q[wrPtr_q] <= in_data_i;
        end
    end

endmodule
